// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase sequencer.
// Optional feature macro: TRAFFIC_NIGHT_FLASH_EN adds the FLASH phase.
package traffic_pkg;

  typedef enum logic [2:0] {
    RED_NS    = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    RED_EW    = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
`ifdef TRAFFIC_NIGHT_FLASH_EN
    ,
    FLASH     = 3'd6
`endif
  } phase_e;

  typedef logic [2:0] light_t;

  localparam light_t LIGHT_RED    = 3'b100;
  localparam light_t LIGHT_YELLOW = 3'b010;
  localparam light_t LIGHT_GREEN  = 3'b001;
  localparam light_t LIGHT_OFF    = 3'b000;

  // Fixed phase ring; anything outside the ring restarts at RED_NS.
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      RED_NS:    return NS_GREEN;
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return RED_EW;
      RED_EW:    return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      default:   return RED_NS;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter holding the seconds remaining in the current phase (minus one).
module phase_timer #(
  parameter int           W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] rem,
  output logic         zero
);

  // Load has priority over decrement; the count only moves on a qualified tick.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)    rem <= RST_VAL;
    else if (load) rem <= load_val;
    else if (dec)  rem <= rem - W'(1);
  end

  assign zero = (rem == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road phase sequencer: steps the NS/EW light heads through the fixed phase ring
// on each gated 1 s tick and exports the seconds left for the countdown display.
// Optional feature macro: TRAFFIC_NIGHT_FLASH_EN (night_mode input, flashing-yellow FLASH phase).
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter  int pGREEN_SEC   = 25,
  parameter  int pYELLOW_SEC  = 3,
  parameter  int pALL_RED_SEC = 2,
  localparam int pMAX_SEC     = (pGREEN_SEC > pYELLOW_SEC)
                                ? ((pGREEN_SEC  > pALL_RED_SEC) ? pGREEN_SEC  : pALL_RED_SEC)
                                : ((pYELLOW_SEC > pALL_RED_SEC) ? pYELLOW_SEC : pALL_RED_SEC),
  localparam int W            = $clog2(pMAX_SEC + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         sec_tick,
  input  logic         sec_pre,
`ifdef TRAFFIC_NIGHT_FLASH_EN
  input  logic         night_mode,
`endif
  output logic         cnt_en,
  output light_t       ns_light,
  output light_t       ew_light,
  output logic [W-1:0] sec_left,
  output logic         phase_end
);

  if ((pGREEN_SEC < 1) || (pYELLOW_SEC < 1) || (pALL_RED_SEC < 1)) begin : g_bad_duration
    $error("traffic_phase_ctrl: every phase duration must be at least 1 second");
  end

  phase_e       state, state_nxt;
  logic         load, dec, zero;
  logic [W-1:0] load_val, rem;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic         flash_on, flash_on_nxt;
`endif

  // Counter load value for a phase: its duration minus the second already being shown.
  function automatic logic [W-1:0] dur_m1(input phase_e p);
    case (p)
      NS_GREEN, EW_GREEN:   return W'(pGREEN_SEC - 1);
      NS_YELLOW, EW_YELLOW: return W'(pYELLOW_SEC - 1);
      default:              return W'(pALL_RED_SEC - 1);
    endcase
  endfunction

  phase_timer #(
    .W       (W),
    .RST_VAL (W'(pALL_RED_SEC - 1))
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .rem      (rem),
    .zero     (zero)
  );

  // Phase register (and flash half-second tracker when night flashing is built in).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RED_NS;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      flash_on <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      flash_on <= flash_on_nxt;
`endif
    end
  end

  // Next phase and counter control; only a tick while running moves anything.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt = state;
    load      = 1'b0;
    load_val  = '0;
    dec       = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    flash_on_nxt = flash_on;
`endif
    if (sec_tick && run) begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
      if (night_mode) begin
        state_nxt    = FLASH;
        load         = 1'b1;
        flash_on_nxt = (state == FLASH) ? !flash_on : 1'b1;
      end else if (state == FLASH) begin
        state_nxt = RED_NS;
        load      = 1'b1;
        load_val  = dur_m1(RED_NS);
      end else
`endif
      if (zero) begin
        state_nxt = next_phase(state);
        load      = 1'b1;
        load_val  = dur_m1(next_phase(state));
      end else begin
        dec = 1'b1;
      end
    end
  end

  // Moore light decode: the road without right of way is always red.
  always_comb begin
    ns_light = LIGHT_RED;
    ew_light = LIGHT_RED;
    case (state)
      NS_GREEN:  ns_light = LIGHT_GREEN;
      NS_YELLOW: ns_light = LIGHT_YELLOW;
      EW_GREEN:  ew_light = LIGHT_GREEN;
      EW_YELLOW: ew_light = LIGHT_YELLOW;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      FLASH: begin
        ns_light = flash_on ? LIGHT_YELLOW : LIGHT_OFF;
        ew_light = flash_on ? LIGHT_YELLOW : LIGHT_OFF;
      end
`endif
      default: ;
    endcase
  end

  // Display and handshake outputs; rem never exceeds pMAX_SEC-1 so rem+1 fits in W bits.
  always_comb begin
    cnt_en    = run;
    sec_left  = rem + W'(1);
    phase_end = run & sec_pre & zero;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    if (state == FLASH) begin
      sec_left  = '0;
      phase_end = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: a default instance and a (1,1,1) instance share
// the stimulus; a seconds-based reference model predicts every cycle's outputs into a queue
// that a negedge monitor drains and compares.
module tb_traffic_phase_ctrl;

  localparam int NI = 2;

`ifdef TRAFFIC_NIGHT_FLASH_EN
  localparam bit NIGHT = 1'b1;
`else
  localparam bit NIGHT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, run, sec_tick, sec_pre, night_mode;

  logic       cnt_en_a, phase_end_a, cnt_en_b, phase_end_b;
  logic [2:0] ns_a, ew_a, ns_b, ew_b;
  logic [4:0] sec_left_a;
  logic [0:0] sec_left_b;

  always #5 clk = ~clk;

  traffic_phase_ctrl dut_a (
    .clk (clk), .rst_n (rst_n), .run (run), .sec_tick (sec_tick), .sec_pre (sec_pre),
`ifdef TRAFFIC_NIGHT_FLASH_EN
    .night_mode (night_mode),
`endif
    .cnt_en (cnt_en_a), .ns_light (ns_a), .ew_light (ew_a),
    .sec_left (sec_left_a), .phase_end (phase_end_a)
  );

  traffic_phase_ctrl #(.pGREEN_SEC(1), .pYELLOW_SEC(1), .pALL_RED_SEC(1)) dut_b (
    .clk (clk), .rst_n (rst_n), .run (run), .sec_tick (sec_tick), .sec_pre (sec_pre),
`ifdef TRAFFIC_NIGHT_FLASH_EN
    .night_mode (night_mode),
`endif
    .cnt_en (cnt_en_b), .ns_light (ns_b), .ew_light (ew_b),
    .sec_left (sec_left_b), .phase_end (phase_end_b)
  );

  // Reference model: phase index in the 6-step ring plus whole seconds elapsed in it.
  int         dur [NI][6];
  int         mp [NI];
  int         ms [NI];
  bit         mfl [NI];
  bit         mfy [NI];
  logic [2:0] ns_tab [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   div = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h (cnt_en,ns,ew,phase_end,sec_left)",
               name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mp[i] = 0; ms[i] = 0; mfl[i] = 1'b0; mfy[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit r, input bit t, input bit n);
    if (!(r && t)) return;
    for (int i = 0; i < NI; i++) begin
      if (NIGHT && n) begin
        mfy[i] = mfl[i] ? !mfy[i] : 1'b1;
        mfl[i] = 1'b1;
      end else if (mfl[i]) begin
        mfl[i] = 1'b0; mp[i] = 0; ms[i] = 0;
      end else begin
        ms[i]++;
        if (ms[i] == dur[i][mp[i]]) begin
          mp[i] = (mp[i] + 1) % 6;
          ms[i] = 0;
        end
      end
    end
  endtask

  function automatic logic [15:0] expect_out(input int i, input bit r, input bit pr);
    logic [2:0] ns, ew;
    int         left;
    bit         pe;
    if (mfl[i]) begin
      ns = mfy[i] ? 3'b010 : 3'b000;
      ew = ns;
      left = 0;
      pe = 1'b0;
    end else begin
      ns = ns_tab[mp[i]];
      ew = ew_tab[mp[i]];
      left = dur[i][mp[i]] - ms[i];
      pe = r && pr && (left == 1);
    end
    return {r, ns, ew, pe, 8'(left)};
  endfunction

  // One clock: model follows the edge just taken, then new inputs land between edges.
  task automatic cycle(input bit r, input bit t, input bit pr, input bit n, input bit rs);
    exp_t e;
    @(posedge clk);
    if (rst_n) model_edge(run, sec_tick, night_mode);
    #1;
    run = r; sec_tick = t; sec_pre = pr; night_mode = NIGHT ? n : 1'b0; rst_n = rs;
    if (!rs) model_reset();
    e.a = expect_out(0, r, pr);
    e.b = expect_out(1, r, pr);
    sb.push_back(e);
  endtask

  // Emulated seconds divider (4 clk per second), enabled by run and reloaded when stopped.
  task automatic reg_cycle(input bit r, input bit n);
    bit t, pr;
    t = 1'b0; pr = 1'b0;
    if (r) begin
      t   = (div == 3);
      pr  = (div == 2);
      div = (div + 1) % 4;
    end else begin
      div = 0;
    end
    cycle(r, t, pr, n, 1'b1);
  endtask

  // Monitor: compare each presented cycle against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("dut_a", {cnt_en_a, ns_a, ew_a, phase_end_a, 8'(sec_left_a)}, e.a);
      check("dut_b", {cnt_en_b, ns_b, ew_b, phase_end_b, 8'(sec_left_b)}, e.b);
    end
  end

  initial begin
    dur[0] = '{2, 25, 3, 2, 25, 3};
    dur[1] = '{1, 1, 1, 1, 1, 1};
    rst_n = 1'b0; run = 1'b0; sec_tick = 1'b0; sec_pre = 1'b0; night_mode = 1'b0;
    model_reset();

    // Reset state, then full cycles at one tick per 4 clk.
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (300) reg_cycle(1'b1, 1'b0);

    // Freeze mid NS green with ticks and pre-ticks still toggling, then resume.
    for (int k = 0; k < 1000 && !(mp[0] == 1 && ms[0] == 10); k++) reg_cycle(1'b1, 1'b0);
    check("reach_ns_green", 16'(mp[0] == 1 && ms[0] == 10), 16'd1);
    for (int k = 0; k < 50; k++) cycle(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b1);
    repeat (120) reg_cycle(1'b1, 1'b0);

    // Asynchronous reset pulse in the middle of EW yellow.
    for (int k = 0; k < 1000 && mp[0] != 5; k++) reg_cycle(1'b1, 1'b0);
    check("reach_ew_yellow", 16'(mp[0] == 5), 16'd1);
    repeat (2) reg_cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    div = 0;
    repeat (60) reg_cycle(1'b1, 1'b0);

    // Night flashing entered from NS green and left again.
    if (NIGHT) begin
      for (int k = 0; k < 1000 && mp[0] != 1; k++) reg_cycle(1'b1, 1'b0);
      repeat (40) reg_cycle(1'b1, 1'b1);
      repeat (20) reg_cycle(1'b1, 1'b0);
    end

    // Random mix: stalls, irregular and overlapping tick/pre, night toggles, rare resets.
    begin
      bit n;
      n = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        bit r;
        r = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 49) == 0) n = !n;
        if ($urandom_range(0, 4) == 0)
          cycle(r, 1'($urandom), 1'($urandom), n, ($urandom_range(0, 199) != 0));
        else
          reg_cycle(r, n);
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
